// File: rtl/uart_tx_wrapper.sv
// uart_tx_wrapper: 32-bit word FIFO feeding an 8N1 UART transmitter, bytes sent LSB first
module uart_tx_wrapper #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_valid,
  input  logic [31:0] data_in,
  output logic        ready,
  output logic        io_tx,
  output logic        busy
);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   shreg;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic          push, pop, bit_end;
  assign ready   = count != (AW+1)'(FIFO_DEPTH);
  assign push    = data_valid & ready;
  assign pop     = (state == IDLE) & (count != '0);
  assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
  // word storage; emptiness is tracked by count, so the array needs no reset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data_in;
  // FIFO pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // transmit FSM; io_tx is registered from the current state, one clock behind it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      io_tx    <= 1'b1;
      shreg    <= '0;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      baud <= (state == IDLE || bit_end) ? '0 : baud + 1'b1;
      case (state)
        IDLE: begin
          io_tx <= 1'b1;
          if (pop) begin
            shreg    <= mem[rd_ptr];
            byte_idx <= '0;
            state    <= START;
          end
        end
        START: begin
          io_tx <= 1'b0;
          if (bit_end) begin
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          io_tx <= shreg[0];
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          io_tx <= 1'b1;
          if (bit_end) begin
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 1'b1;
              state    <= START;
            end else state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  // busy flag registered from FSM state and FIFO occupancy
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) busy <= 1'b0;
    else busy <= (state != IDLE) | (count != '0);
endmodule

// File: tb/tb_uart_tx_wrapper.sv
// tb_uart_tx_wrapper: directed checks of the word FIFO and 8N1 serialiser with a mid-bit UART monitor
module tb_uart_tx_wrapper;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        reset_n, data_valid, ready, io_tx, busy;
  logic [31:0] data_in;
  int          checks = 0, errors = 0, cyc = 0, falls = 0, rst_cnt = 0;
  logic [7:0]  rx_q[$];
  int          rx_t[$];
  logic [31:0] words [6] = '{32'hDEADBEEF, 32'h12345678, 32'hA5A55A5A,
                             32'h0F0F0F0F, 32'hCAFEF00D, 32'hBADBADBA};

  uart_tx_wrapper #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .data_valid(data_valid), .data_in(data_in),
    .ready(ready), .io_tx(io_tx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge io_tx) falls++;
  always @(negedge reset_n) rst_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    data_valid = 1'b1;
    data_in    = w;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int k;
    k = 0;
    while (rx_q.size() < n && k < 3000) begin
      tick();
      k++;
    end
    check("rx_count", rx_q.size(), n);
  endtask

  task automatic check_word(input string tag, input int base, input logic [31:0] w);
    for (int j = 0; j < 4; j++) check(tag, {24'h0, rx_q[base+j]}, {24'h0, w[8*j +: 8]});
  endtask

  // UART monitor: samples every bit in its middle, drops frames interrupted by reset
  initial forever begin
    logic [7:0] b;
    logic       s0, s1;
    int         t, r;
    @(negedge io_tx);
    r = rst_cnt;
    repeat (CPB / 2) @(posedge clk);
    #1;
    s0 = io_tx;
    t  = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1;
      b[i] = io_tx;
    end
    repeat (CPB) @(posedge clk);
    #1;
    s1 = io_tx;
    if (r == rst_cnt) begin
      check("start_bit", {31'h0, s0}, 32'h0);
      check("stop_bit", {31'h0, s1}, 32'h1);
      rx_q.push_back(b);
      rx_t.push_back(t);
    end
  end

  initial begin
    int lows, fb, k;
    logic [31:0] w;
    reset_n    = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (3) tick();
    check("rst_io_tx", {31'h0, io_tx}, 32'h1);
    check("rst_ready", {31'h0, ready}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    reset_n = 1'b1;
    tick();
    check("post_rst_io_tx", {31'h0, io_tx}, 32'h1);
    check("post_rst_ready", {31'h0, ready}, 32'h1);
    check("post_rst_busy", {31'h0, busy}, 32'h0);
    lows = 0;
    fb   = falls;
    repeat (100) begin
      tick();
      if (io_tx !== 1'b1) lows++;
    end
    check("idle_low_cycles", lows, 0);
    check("idle_falls", falls - fb, 0);

    // single word: start bit 2 edges after accept, busy drops 161 edges after START entry
    rx_q.delete();
    rx_t.delete();
    push(32'h11223344);
    tick();
    check("pre_start_io_tx", {31'h0, io_tx}, 32'h1);
    tick();
    check("start_latency", {31'h0, io_tx}, 32'h0);
    repeat (159) tick();
    check("busy_before_end", {31'h0, busy}, 32'h1);
    tick();
    check("busy_after_end", {31'h0, busy}, 32'h0);
    wait_rx(4);
    check_word("word_11223344", 0, 32'h11223344);

    // all-zero then all-one words: exact levels, back-to-back bytes, one idle clock between words
    rx_q.delete();
    rx_t.delete();
    push(32'h00000000);
    push(32'hFFFFFFFF);
    wait_rx(8);
    check_word("word_zeros", 0, 32'h00000000);
    check_word("word_ones", 4, 32'hFFFFFFFF);
    for (int i = 0; i < 7; i++) check("byte_spacing", rx_t[i+1] - rx_t[i], (i == 3) ? 41 : 40);

    // six pushes: one popped at once, four fill the FIFO, sixth dropped; then a push during the pop
    rx_q.delete();
    rx_t.delete();
    for (int i = 0; i < 6; i++) push(words[i]);
    check("full_ready", {31'h0, ready}, 32'h0);
    data_valid = 1'b1;
    data_in    = 32'h77777777;
    k = 0;
    while (ready !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    data_valid = 1'b0;
    check("ready_after_pop", {31'h0, ready}, 32'h1);
    check("count_after_pop", {29'h0, dut.count}, DEPTH - 1);
    wait_rx(20);
    for (int i = 0; i < 5; i++) begin
      w = words[i];
      check_word("fifo_order", 4 * i, w);
    end
    k = 0;
    while (busy !== 1'b0 && k < 1000) begin
      tick();
      k++;
    end
    repeat (60) tick();
    check("no_extra_bytes", rx_q.size(), 20);

    // reset in the middle of byte 2 data bits with two words still queued
    rx_q.delete();
    rx_t.delete();
    push(32'h00000000);
    push(32'h11111111);
    push(32'h22222222);
    repeat (100) tick();
    check("pre_rst_low", {31'h0, io_tx}, 32'h0);
    reset_n = 1'b0;
    #1;
    check("abort_io_tx", {31'h0, io_tx}, 32'h1);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_ready", {31'h0, ready}, 32'h1);
    repeat (3) tick();
    reset_n = 1'b1;
    rx_q.delete();
    rx_t.delete();
    fb = falls;
    repeat (300) tick();
    check("abort_no_falls", falls - fb, 0);
    check("abort_no_bytes", rx_q.size(), 0);
    check("abort_busy_idle", {31'h0, busy}, 32'h0);

    // push on the very first edge after reset release
    reset_n = 1'b0;
    tick();
    data_valid = 1'b1;
    data_in    = 32'h5AC396E1;
    #2;
    reset_n = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    check("first_push_pre", {31'h0, io_tx}, 32'h1);
    tick();
    check("first_push_start", {31'h0, io_tx}, 32'h0);
    wait_rx(4);
    check_word("first_push_word", 0, 32'h5AC396E1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
